bcd_to_bin_sequencer: RTL and testbench

//  Sequential BCD-to-binary converter for the reaction-time display/entry path.

---
 rtl/bcd_to_bin_sequencer_if.sv | 24 ++
 rtl/bcd_to_bin_sequencer.sv | 133 +++++++++++++
 tb/tb_bcd_to_bin_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_sequencer_if.sv
// Request/response bundle between the digit-entry logic and the BCD-to-binary sequencer.
// The master owns start/bcd_in; the sequencer (slave) owns the status and result.
interface bcd_to_bin_sequencer_if #(
    parameter int NDIGITS = 4,
    parameter int WIDTH   = 13
);
    logic                   start;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       result;
    logic                   ovf;
    logic                   err;

    modport master (
        output start, bcd_in,
        input  busy, done, result, ovf, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, result, ovf, err
    );
endinterface

// File: rtl/bcd_to_bin_sequencer.sv
// Sequential BCD-to-binary converter: one shared x10/add step per cycle, MSD first (Horner).
// Feeds the 13-bit binary timing comparator from the digit-entry/score path.
module bcd_to_bin_sequencer #(
    parameter int NDIGITS = 4,
    parameter int WIDTH   = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_to_bin_sequencer_if.slave   bus
);

    localparam int BW = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t             state, state_n;
    logic [BW-1:0]      digits, digits_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [IW-1:0]      idx, idx_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [WIDTH-1:0]   result_q, result_n;
    logic               ovf_q, ovf_n;
    logic               err_q, err_n;

    logic               bad_digit;
    logic [3:0]         cur_digit;
    logic [WIDTH+3:0]   acc_ext;
    logic [WIDTH+3:0]   mac_sum;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) cur_digit = digits[4*i +: 4];
        end
    end

    // Exact Horner step kept 4 bits wider so the overflow flag sees the true sum.
    always_comb begin
        acc_ext = {4'b0000, acc};
        mac_sum = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, cur_digit};
    end

    always_comb begin
        state_n  = state;
        digits_n = digits;
        acc_n    = acc;
        idx_n    = idx;
        busy_n   = busy_q;
        done_n   = 1'b0;
        result_n = result_q;
        ovf_n    = ovf_q;
        err_n    = err_q;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.start) begin
                    digits_n = bus.bcd_in;
                    acc_n    = '0;
                    ovf_n    = 1'b0;
                    err_n    = bad_digit;
                    idx_n    = IW'(NDIGITS - 1);
                    busy_n   = 1'b1;
                    if (bad_digit) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        result_n = '0;
                    end else begin
                        state_n  = MAC;
                    end
                end
            end
            MAC: begin
                acc_n = mac_sum[WIDTH-1:0];
                if (mac_sum[WIDTH+3:WIDTH] != 4'd0) ovf_n = 1'b1;
                idx_n = idx - IW'(1);
                if (idx == '0) begin
                    state_n  = DONE;
                    done_n   = 1'b1;
                    result_n = mac_sum[WIDTH-1:0];
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Status outputs are registered so result/ovf/err are stable during the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            digits   <= '0;
            acc      <= '0;
            idx      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            digits   <= digits_n;
            acc      <= acc_n;
            idx      <= idx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            result_q <= result_n;
            ovf_q    <= ovf_n;
            err_q    <= err_n;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_sequencer.sv
// Randomised self-checking bench for bcd_to_bin_sequencer against a plain-arithmetic model.
module tb_bcd_to_bin_sequencer;

    localparam int NDIGITS = 4;
    localparam int WIDTH   = 13;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bcd_to_bin_sequencer_if #(.NDIGITS(NDIGITS), .WIDTH(WIDTH)) bus ();

    bcd_to_bin_sequencer #(.NDIGITS(NDIGITS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: weigh each decimal digit by its power of ten, then reduce modulo 2^WIDTH.
    task automatic modelConvert(input logic [15:0] bcd, output logic [WIDTH-1:0] res,
                                output logic o, output logic e);
        int value;
        int weight;
        value  = 0;
        weight = 1;
        e      = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            int d;
            d = int'(bcd[4*i +: 4]);
            if (d > 9) e = 1'b1;
            value  = value + d * weight;
            weight = weight * 10;
        end
        if (e) begin
            res = '0;
            o   = 1'b0;
        end else begin
            res = WIDTH'(value % (1 << WIDTH));
            o   = (value >= (1 << WIDTH));
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "/busy"},   32'(bus.busy),   0);
        checkOutput({tag, "/done"},   32'(bus.done),   0);
        checkOutput({tag, "/result"}, 32'(bus.result), 0);
        checkOutput({tag, "/ovf"},    32'(bus.ovf),    0);
        checkOutput({tag, "/err"},    32'(bus.err),    0);
    endtask

    // Call at a negedge; returns at the negedge of the idle cycle after done.
    task automatic applyStimulus(input logic [15:0] bcd, input bit junk, input string tag);
        logic [WIDTH-1:0] er;
        logic             eo, ee;
        int               explat, lat;
        modelConvert(bcd, er, eo, ee);
        explat     = ee ? 1 : NDIGITS + 1;
        bus.bcd_in = bcd;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat        = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            checkOutput({tag, "/busy_mac"}, 32'(bus.busy), 1);
            if (junk) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.bcd_in = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            checkOutput({tag, "/done_timeout"}, 32'(bus.done), 1);
        end else begin
            checkOutput({tag, "/latency"},   32'(lat),        32'(explat));
            checkOutput({tag, "/busy_done"}, 32'(bus.busy),   1);
            checkOutput({tag, "/result"},    32'(bus.result), 32'(er));
            checkOutput({tag, "/ovf"},       32'(bus.ovf),    32'(eo));
            checkOutput({tag, "/err"},       32'(bus.err),    32'(ee));
        end
        @(negedge clk);
        checkOutput({tag, "/done_pulse"},  32'(bus.done),   0);
        checkOutput({tag, "/busy_idle"},   32'(bus.busy),   0);
        checkOutput({tag, "/result_hold"}, 32'(bus.result), 32'(er));
        checkOutput({tag, "/ovf_hold"},    32'(bus.ovf),    32'(eo));
        checkOutput({tag, "/err_hold"},    32'(bus.err),    32'(ee));
    endtask

    initial begin
        logic [15:0] rnd;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;

        repeat (3) @(negedge clk);
        checkIdleZero("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkIdleZero("after_reset");
        end

        applyStimulus(16'h1234, 1'b0, "h1234");
        @(negedge clk);
        applyStimulus(16'h8191, 1'b0, "h8191");
        applyStimulus(16'h8192, 1'b0, "h8192");
        applyStimulus(16'h9999, 1'b0, "h9999");
        @(negedge clk);
        applyStimulus(16'h12A4, 1'b0, "h12A4");
        applyStimulus(16'h0042, 1'b0, "h0042");
        @(negedge clk);
        applyStimulus(16'h0500, 1'b1, "h0500_junk");
        applyStimulus(16'h0377, 1'b0, "back_to_back");

        // Abort a conversion with reset two cycles in.
        @(negedge clk);
        bus.bcd_in = 16'h7777;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleZero("abort");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(bus.done), 0);
            if (i == 2) rst_n = 1'b1;
        end
        applyStimulus(16'h0001, 1'b0, "h0001");

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if ($urandom_range(0, 15) == 0) rnd[4*i +: 4] = 4'($urandom_range(10, 15));
                else                            rnd[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(rnd, 1'($urandom_range(0, 1)), $sformatf("rand%0d_%h", n, rnd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
